// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 single-precision add/subtract sequencer.
// Walks one operand pair through UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE
// on a 28-bit mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.
// Denormal inputs flush to zero, tiny results flush to signed zero, rounding is RNE.
// Optional: define FP_ADD_SEQ_FLAGS_EN to add flags[3:0] = {invalid, overflow, underflow, inexact}.
module fp_add_seq #(
  parameter int MAX_NORM_SHIFT = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
`ifdef FP_ADD_SEQ_FLAGS_EN
  output logic [3:0]  flags,
`endif
  output logic        busy
);

  localparam int CW = $clog2(MAX_NORM_SHIFT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_NORM_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          sub_q, sub_d;
  logic          sign_q, sign_d;
  logic          eff_sub_q, eff_sub_d;
  logic [9:0]    exp_q, exp_d;       // wide enough that carry/round never wraps
  logic [7:0]    diff_q, diff_d;
  logic [27:0]   ma_q, ma_d, mb_q, mb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   result_q, result_d;
  logic          out_valid_q, out_valid_d;
`ifdef FP_ADD_SEQ_FLAGS_EN
  logic [3:0]    flags_q, flags_d;
`endif

  // ---- operand decode (B carries the effective sign after op_sub) ----
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sa, sb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge_b;
  logic [27:0] ma_un, mb_un;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign sa     = a_q[31];
  assign sb     = b_q[31] ^ sub_q;
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_ge_b = (a_q[30:0] >= b_q[30:0]);
  assign ma_un  = {2'b01, fa, 3'b000};
  assign mb_un  = {2'b01, fb, 3'b000};

`ifdef FP_ADD_SEQ_FLAGS_EN
  logic a_den, b_den;
  assign a_den = a_zero && (fa != 23'd0);
  assign b_den = b_zero && (fb != 23'd0);
`endif

  // ---- align: right shift smaller mantissa, fold lost bits into sticky ----
  logic [27:0] mb_shr, lost_mask, mb_aligned;
  assign mb_shr     = mb_q >> diff_q;
  assign lost_mask  = (28'd1 << diff_q) - 28'd1;
  assign mb_aligned = (diff_q >= 8'd27) ? {27'd0, |mb_q}
                                        : (mb_shr | {27'd0, |(mb_q & lost_mask)});

  // ---- add: magnitudes are pre-ordered so subtraction never goes negative ----
  logic [27:0] sum_raw;
  assign sum_raw = eff_sub_q ? (ma_q - mb_q) : (ma_q + mb_q);

  // ---- round to nearest even on m[26:3] ----
  logic        rnd_inc, rnd_ovf;
  logic [24:0] m_rnd;
  logic [9:0]  exp_rnd;
  logic [22:0] frac_rnd;
  assign rnd_inc  = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
  assign m_rnd    = {1'b0, ma_q[26:3]} + {24'd0, rnd_inc};
  assign exp_rnd  = m_rnd[24] ? (exp_q + 10'd1) : exp_q;
  assign frac_rnd = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
  assign rnd_ovf  = (exp_rnd >= 10'd255);

  // Next-state and datapath updates for every sequencer step
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    exp_d       = exp_q;
    diff_d      = diff_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef FP_ADD_SEQ_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          cnt_d   = '0;
          state_d = S_UNPACK;
`ifdef FP_ADD_SEQ_FLAGS_EN
          flags_d = 4'b0000;
`endif
        end
      end
      S_UNPACK: begin
        state_d = S_DONE;
`ifdef FP_ADD_SEQ_FLAGS_EN
        if (a_den || b_den) flags_d[1] = 1'b1;
`endif
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          result_d = 32'h7FC0_0000;
`ifdef FP_ADD_SEQ_FLAGS_EN
          flags_d[3] = 1'b1;
`endif
        end else if (a_inf) begin
          result_d = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
          result_d = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
          result_d = {sa & sb, 31'd0};
        end else if (a_zero) begin
          result_d = {sb, b_q[30:0]};
        end else if (b_zero) begin
          result_d = a_q;
        end else begin
          state_d   = S_ALIGN;
          eff_sub_d = sa ^ sb;
          if (a_ge_b) begin
            sign_d = sa;
            exp_d  = {2'b00, ea};
            diff_d = ea - eb;
            ma_d   = ma_un;
            mb_d   = mb_un;
          end else begin
            sign_d = sb;
            exp_d  = {2'b00, eb};
            diff_d = eb - ea;
            ma_d   = mb_un;
            mb_d   = ma_un;
          end
        end
      end
      S_ALIGN: begin
        mb_d    = mb_aligned;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sum_raw == 28'd0) begin
          result_d = 32'd0;
          state_d  = S_DONE;
        end else begin
          state_d = S_NORM;
          if (sum_raw[27]) begin
            ma_d  = {1'b0, sum_raw[27:1]} | {27'd0, sum_raw[0]};
            exp_d = exp_q + 10'd1;
          end else begin
            ma_d = sum_raw;
          end
        end
      end
      S_NORM: begin
        if (ma_q[26]) begin
          state_d = S_ROUND;
        end else if (exp_q > 10'd1) begin
          ma_d  = ma_q << 1;
          exp_d = exp_q - 10'd1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          // would go subnormal: flush to zero, keep the sign
          result_d = {sign_q, 31'd0};
          state_d  = S_DONE;
`ifdef FP_ADD_SEQ_FLAGS_EN
          flags_d[1] = 1'b1;
`endif
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (rnd_ovf) begin
          result_d = {sign_q, 8'hFF, 23'd0};
`ifdef FP_ADD_SEQ_FLAGS_EN
          flags_d[2] = 1'b1;
          flags_d[0] = 1'b1;
`endif
        end else begin
          result_d = {sign_q, exp_rnd[7:0], frac_rnd};
`ifdef FP_ADD_SEQ_FLAGS_EN
          if (|ma_q[2:0]) flags_d[0] = 1'b1;
`endif
        end
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      diff_q      <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef FP_ADD_SEQ_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      exp_q       <= exp_d;
      diff_q      <= diff_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef FP_ADD_SEQ_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
`ifdef FP_ADD_SEQ_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed vector table, multi-cycle corner sequences
// (backpressure, reset mid-normalise) and random operands against an
// exact wide-integer reference model.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;
`ifdef FP_ADD_SEQ_FLAGS_EN
  logic [3:0]  flags;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fp_add_seq #(.MAX_NORM_SHIFT(27)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result),
`ifdef FP_ADD_SEQ_FLAGS_EN
    .flags(flags),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, summed in
  // 300 bits, then rounded to 24 significant bits (RNE) with flush-to-zero.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [299:0] va, vb, sm, keep, rem, half, one;
    logic sa, sb, sr;
    int ea, eb, p, e;
    sa = a[31]; sb = b[31] ^ s;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 255 && sa != sb)) return 32'h7FC00000;
    if (ea == 255) return {sa, 31'h7F800000};
    if (eb == 255) return {sb, 31'h7F800000};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
    if (ea == 0) return {sb, b[30:0]};
    if (eb == 0) return a;
    one = 1;
    va = {276'd0, 1'b1, a[22:0]} << (ea - 1);
    vb = {276'd0, 1'b1, b[22:0]} << (eb - 1);
    if (sa == sb) begin sm = va + vb; sr = sa; end
    else if (va >= vb) begin sm = va - vb; sr = sa; end
    else begin sm = vb - va; sr = sb; end
    if (sm == 0) return 32'd0;
    p = -1;
    for (int i = 299; i >= 0; i--) if (sm[i] && p < 0) p = i;
    e = p - 22;
    if (e < 1) return {sr, 31'd0};
    if (p > 23) begin
      keep = sm >> (p - 23);
      rem  = sm & ((one << (p - 23)) - one);
      half = one << (p - 24);
      if (rem > half || (rem == half && keep[0])) keep = keep + one;
    end else keep = sm;
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) return {sr, 31'h7F800000};
    return {sr, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input int base_e);
    int e;
    logic [31:0] sp [6];
    logic [31:0] r;
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
    sp[3] = 32'hFF800000; sp[4] = 32'h7FC00000; sp[5] = 32'h00000123;
    if ($urandom_range(0, 11) == 0) return sp[$urandom_range(0, 5)];
    e = base_e + int'($urandom_range(0, 60)) - 30;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    r = {1'b0, e[7:0], 23'(($urandom()))};
    r[31] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Issue one transaction; return result and edges from accept to out_valid.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] res, output int lat, output bit ir_bad);
    int g;
    g = 0; ir_bad = 0; lat = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do begin
      @(posedge clk); #1; lat++;
      if (!out_valid && in_ready) ir_bad = 1;
    end while (!out_valid && lat < 200);
    res = result;
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: out_valid not seen for %h %h", a, b);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    int          lat;
    logic [3:0]  fl;
    bit          cf;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] res, held;
    int lat;
    bit irb, ov_seen;

    #20000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, held;
    int lat;
    bit irb, ov_seen;

    tbl[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6,  4'b0000, 1'b1};
    tbl[1]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 30, 4'b0000, 1'b1};
    tbl[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 6,  4'b0001, 1'b1};
    tbl[3]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 6,  4'b0001, 1'b1};
    tbl[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2,  4'b1000, 1'b1};
    tbl[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 6,  4'b0101, 1'b1};
    tbl[6]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4,  4'b0000, 1'b1};
    tbl[7]  = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 2,  4'b0000, 1'b1};
    tbl[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2,  4'b0000, 1'b1};
    tbl[9]  = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 2,  4'b0000, 1'b1};
    tbl[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 2,  4'b1000, 1'b1};
    tbl[11] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2,  4'b0000, 1'b1};
    tbl[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 6,  4'b0000, 1'b1};
    tbl[13] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 2,  4'b0010, 1'b1};
    tbl[14] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 2,  4'b0000, 1'b1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // directed vectors
    for (int i = 0; i < 15; i++) begin
      do_txn(tbl[i].a, tbl[i].b, tbl[i].s, res, lat, irb);
      chk($sformatf("vec%0d_result", i), res, tbl[i].r);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_in_ready_low", i), {31'd0, irb}, 32'd0);
`ifdef FP_ADD_SEQ_FLAGS_EN
      if (tbl[i].cf) chk($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, tbl[i].fl});
`endif
    end

    // backpressure: DONE holds result, in_valid pulses are ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_txn(32'h3F800000, 32'h3F800000, 1'b0, held, lat, irb);
    chk("bp_result", held, 32'h40000000);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op_a = $urandom(); op_b = $urandom(); op_sub = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_stable_%0d", k), result, held);
      chk($sformatf("bp_busy_%0d", k), {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // reset during the long normalise of the 24-shift case
    op_a = 32'h3F800000; op_b = 32'h3F7FFFFF; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1;
    end
    chk("mid_rst_no_output", {31'd0, ov_seen}, 32'd0);
    do_txn(32'h3F800000, 32'h3F7FFFFF, 1'b1, res, lat, irb);
    chk("post_rst_result", res, 32'h33800000);
    chk("post_rst_latency", lat, 30);

    // random operands against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      int be;
      be = int'($urandom_range(1, 254));
      ra = rand_op(be);
      rb = (i % 7 == 0) ? (ra ^ 32'(($urandom_range(0, 3)))) : rand_op(be);
      rs = 1'($urandom_range(0, 1));
      do_txn(ra, rb, rs, res, lat, irb);
      chk($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rs), res, model(ra, rb, rs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
- Multi-cycle sequencer for IEEE-754 single-precision add/subtract, built on the team's 28-bit mantissa datapath format.
- Takes one operand pair per transaction and steps it through unpack/swap, align, add, normalise, round and pack.
- Uses a valid/ready handshake on both sides.
- Sits between the FP-unit issue logic and the result writeback.

Parameters:
- MAX_NORM_SHIFT, 27: upper bound on left-normalise iterations; sizes the shift counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept; equals (state==IDLE).
- op_a  input  32  IEEE-754 single operand A.
- op_b  input  32  IEEE-754 single operand B.
- op_sub  input  1  1: compute A−B (flip sign of B); 0: A+B.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- result  output  32  IEEE-754 single result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE, out_valid=0, result=0, busy=0.
  - in_ready=1 from the first edge with rst_n high.
  - Reset mid-operation discards the transaction; no output is produced.
- Accept: in_valid&in_ready at an edge latches op_a, op_b and op_sub, then goes to UNPACK. in_ready is 0 until return to IDLE (one transaction in flight).
- Internal mantissa is 28 bits:
  - [27] carry headroom, [26] hidden bit, [25:3] fraction.
  - [2] guard, [1] round, [0] sticky.
- Denormal inputs are flushed to ±0 (exp==0 treated as zero).
- UNPACK (1 cycle):
  - NaN in either operand, or inf+(−inf), gives result=0x7FC00000.
  - Single inf gives that inf with its effective sign.
  - Both zero gives +0, except −0+−0 which gives 0x80000000.
  - Exactly one zero gives the other operand, with effective sign applied to B.
  - All special cases go to DONE.
  - Otherwise swap so that {exp,frac} of A is >= that of B; diff = expA−expB; go to ALIGN.
- ALIGN (1 cycle): mB = mB>>diff; sticky = OR of all shifted-out bits. If diff>=27, mB = {27'b0, |mB_orig}.
- ADD (1 cycle):
  - Signs differ: m = mA−mB; otherwise m = mA+mB.
  - Sign of result = sign of A.
  - If m[27]: m = m>>1 with m[0] |= old m[0]; exp+1.
  - m==0: result=+0, go to DONE.
  - Otherwise go to NORM.
- NORM (one cycle per check):
  - If m[26]==1, go to ROUND.
  - Else if exp>1: m<<=1, exp−=1, shift count+1.
  - Else (exp==1 with no hidden bit): flush to signed zero, go to DONE.
  - Shift count never exceeds MAX_NORM_SHIFT.
- ROUND (1 cycle), round-to-nearest-even:
  - Increment m[26:3] if G & (R|S|m[3]).
  - Mantissa overflow: m>>1, exp+1.
  - exp>=255 gives ±inf (0x7F800000 | sign).
  - Pack into result; go to DONE.
- DONE: out_valid=1 and result stable. out_valid&out_ready at an edge gives IDLE and out_valid=0.
- Latency, counted in edges after the accept edge to the edge at which out_valid is first seen high:
  - Special-case input: 2.
  - Zero sum: 4.
  - Normal path: 6+N, where N = left shifts.
- out_ready held low keeps state DONE indefinitely, with result unchanged.
- in_valid while busy is ignored (not latched).

Optional Feature:
- Macro FP_ADD_SEQ_FLAGS_EN.
- When defined, adds output flags[3:0] = {invalid, overflow, underflow, inexact}, valid with out_valid and held with result; cleared to 0 at reset and at accept.
  - invalid: NaN-producing case.
  - overflow: rounded to inf.
  - underflow: FTZ flush in NORM, or a denormal input flushed.
  - inexact: G|R|S nonzero at ROUND, or overflow.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- 0x3F800000 + 0x3F800000, op_sub=0 → result 0x40000000; out_valid 6 edges after accept; in_ready 0 throughout.
- 0x3F800000 − 0x3F7FFFFF → 0x33800000 after N=24 left shifts; out_valid at edge 30.
- Rounding ties: 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even); 0x3F800001 + 0x33800000 → 0x3F800002.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000 at edge 2 (flags=invalid if enabled).
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 (overflow).
  - 0x3F800000 − 0x3F800000 → 0x00000000 at edge 4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and result stable, in_valid pulses ignored; release → IDLE next edge, in_ready=1.
- Reset during NORM of the 24-shift case → next edge out_valid=0, busy=0; a new transaction afterwards completes correctly.
